// File: rtl/lpf_mem_port_if.sv
// rtl/lpf_mem_port_if.sv - request/response bundle between the lpf initiator and the memory port
// Signals:
//   lpf_flag        request valid, held by the initiator until done_lpf
//   lpf_wr          1 = write, 0 = read
//   lpf_x, lpf_y    pixel column / row
//   lpf_bank        frame-buffer bank select
//   lpf_pixel_write write word
//   done_lpf        one-cycle completion pulse
//   lpf_pixel_read  read word, held until the next read completes
// Modports: master = initiator side, slave = memory port side.
interface lpf_mem_port_if #(
  parameter int LOG_WIDTH  = 10,
  parameter int LOG_HEIGHT = 9,
  parameter int LOG_MEM    = 36
) ();
  logic                  lpf_flag;
  logic                  lpf_wr;
  logic [LOG_WIDTH-1:0]  lpf_x;
  logic [LOG_HEIGHT-1:0] lpf_y;
  logic                  lpf_bank;
  logic [LOG_MEM-1:0]    lpf_pixel_write;
  logic                  done_lpf;
  logic [LOG_MEM-1:0]    lpf_pixel_read;

  modport master (
    output lpf_flag, lpf_wr, lpf_x, lpf_y, lpf_bank, lpf_pixel_write,
    input  done_lpf, lpf_pixel_read
  );

  modport slave (
    input  lpf_flag, lpf_wr, lpf_x, lpf_y, lpf_bank, lpf_pixel_write,
    output done_lpf, lpf_pixel_read
  );
endinterface

// File: rtl/lpf_mem_port.sv
// rtl/lpf_mem_port.sv - memory-side responder for the lpf pixel port onto a pipelined ZBT SRAM
// Ports:
//   clock, reset  system clock, synchronous active-high reset
//   lpf           lpf_mem_port_if.slave request/response bundle
//   ram_addr      ZBT word address
//   ram_we_b      ZBT write enable, active-low
//   ram_wdata     ZBT write data
//   ram_oe        drive-enable for ram_wdata onto the shared data bus
//   ram_rdata     ZBT read data
// One transaction at a time: sample, address, wait, data, done (4-cycle latency).
module lpf_mem_port #(
  parameter int IMAGE_WIDTH  = 640,
  parameter int IMAGE_HEIGHT = 480,
  parameter int LOG_WIDTH    = 10,
  parameter int LOG_HEIGHT   = 9,
  parameter int LOG_MEM      = 36,
  parameter int LOG_ADDR     = 19,
  parameter int BANK_OFFSET  = 153600
) (
  input  logic                clock,
  input  logic                reset,
  lpf_mem_port_if.slave       lpf,
  output logic [LOG_ADDR-1:0] ram_addr,
  output logic                ram_we_b,
  output logic [LOG_MEM-1:0]  ram_wdata,
  output logic                ram_oe,
  input  logic [LOG_MEM-1:0]  ram_rdata
);

  typedef enum logic [2:0] {IDLE, ADDR, WAIT, DATA, DONE} state_t;

  state_t state, state_next;

  logic                wr_q;
  logic                oor_q;
  logic [LOG_ADDR-1:0] addr_q;
  logic [LOG_MEM-1:0]  wdata_q;
  logic [LOG_MEM-1:0]  pixel_read_q;

  logic [LOG_WIDTH-1:0]  req_x;
  logic [LOG_HEIGHT-1:0] req_y;
  logic [LOG_ADDR-1:0]   y_ext;
  logic [LOG_ADDR-1:0]   x_half;
  logic [LOG_ADDR-1:0]   req_addr;
  logic                  req_oor;
  logic                  done;

  assign req_x  = lpf.lpf_x;
  assign req_y  = lpf.lpf_y;
  assign y_ext  = LOG_ADDR'(req_y);
  // x[0] picks the pixel within the word; the initiator handles that half itself
  assign x_half = LOG_ADDR'(req_x >> 1);
  // y*320 as two shifts so no multiplier is needed
  assign req_addr = (lpf.lpf_bank ? LOG_ADDR'(BANK_OFFSET) : '0)
                  + (y_ext << 8) + (y_ext << 6) + x_half;
  assign req_oor  = (int'(req_x) >= IMAGE_WIDTH) || (int'(req_y) >= IMAGE_HEIGHT);

  assign ram_addr           = addr_q;
  assign lpf.done_lpf       = done;
  assign lpf.lpf_pixel_read = pixel_read_q;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_q         <= 1'b0;
      oor_q        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      pixel_read_q <= '0;
    end else begin
      if (state == IDLE && lpf.lpf_flag) begin
        wr_q    <= lpf.lpf_wr;
        oor_q   <= req_oor;
        addr_q  <= req_addr;
        wdata_q <= lpf.lpf_pixel_write;
      end
      // Capture at the end of DATA so the word is already visible in DONE
      if (state == DATA && !wr_q)
        pixel_read_q <= oor_q ? '0 : ram_rdata;
    end
  end

  always_comb begin
    state_next = state;
    done       = 1'b0;
    ram_we_b   = 1'b1;
    ram_oe     = 1'b0;
    ram_wdata  = '0;
    case (state)
      IDLE: if (lpf.lpf_flag) state_next = ADDR;
      ADDR: begin
        ram_we_b   = ~(wr_q & ~oor_q);
        state_next = WAIT;
      end
      WAIT: state_next = DATA;
      DATA: begin
        if (wr_q && !oor_q) begin
          ram_oe    = 1'b1;
          ram_wdata = wdata_q;
        end
        state_next = DONE;
      end
      // The initiator's flag is still high here from the finished request
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    // Release the bus in the same cycle reset is raised
    if (reset) begin
      done      = 1'b0;
      ram_we_b  = 1'b1;
      ram_oe    = 1'b0;
      ram_wdata = '0;
    end
  end

endmodule

// File: tb/tb_lpf_mem_port.sv
// tb/tb_lpf_mem_port.sv - directed self-checking bench for lpf_mem_port with a 2-cycle ZBT model
module tb_lpf_mem_port;

  logic        clock;
  logic        reset;
  logic [18:0] ram_addr;
  logic        ram_we_b;
  logic [35:0] ram_wdata;
  logic        ram_oe;
  logic [35:0] ram_rdata;

  int n_checks;
  int n_fail;

  lpf_mem_port_if bus ();

  lpf_mem_port dut (
    .clock     (clock),
    .reset     (reset),
    .lpf       (bus),
    .ram_addr  (ram_addr),
    .ram_we_b  (ram_we_b),
    .ram_wdata (ram_wdata),
    .ram_oe    (ram_oe),
    .ram_rdata (ram_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ZBT model: address/we in cycle 1, data two edges later in cycle 3
  logic [35:0] mem [0:524287];
  logic [18:0] a1, a2;
  logic        w1, w2;

  always @(posedge clock) begin
    if (reset) begin
      w1 <= 1'b0;
      w2 <= 1'b0;
      mem[642] <= 36'h123456789;
      mem[320] <= 36'hFFFFFFFFF;
      mem[960] <= 36'h000000001;
    end else begin
      a1 <= ram_addr;
      w1 <= ~ram_we_b;
      a2 <= a1;
      w2 <= w1;
      if (w2 && ram_oe) mem[a2] <= ram_wdata;
    end
  end

  assign ram_rdata = mem[a2];

  task automatic step;
    @(posedge clock);
    #2;
  endtask

  task automatic request(input logic wr, input logic [9:0] x, input logic [8:0] y,
                         input logic bank, input logic [35:0] data);
    bus.lpf_flag        = 1'b1;
    bus.lpf_wr          = wr;
    bus.lpf_x           = x;
    bus.lpf_y           = y;
    bus.lpf_bank        = bank;
    bus.lpf_pixel_write = data;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    bus.lpf_flag = 1'b0;
    bus.lpf_wr = 1'b0;
    bus.lpf_x = '0;
    bus.lpf_y = '0;
    bus.lpf_bank = 1'b0;
    bus.lpf_pixel_write = '0;
    step; step; step;
    n_checks++; if (bus.done_lpf !== 1'b0) begin n_fail++; $display("FAIL reset done: got %0b want 0", bus.done_lpf); end
    n_checks++; if (bus.lpf_pixel_read !== 36'h0) begin n_fail++; $display("FAIL reset pixel_read: got %h want 0", bus.lpf_pixel_read); end
    n_checks++; if (ram_addr !== 19'd0) begin n_fail++; $display("FAIL reset ram_addr: got %0d want 0", ram_addr); end
    n_checks++; if (ram_we_b !== 1'b1) begin n_fail++; $display("FAIL reset ram_we_b: got %0b want 1", ram_we_b); end
    n_checks++; if (ram_wdata !== 36'h0) begin n_fail++; $display("FAIL reset ram_wdata: got %h want 0", ram_wdata); end
    n_checks++; if (ram_oe !== 1'b0) begin n_fail++; $display("FAIL reset ram_oe: got %0b want 0", ram_oe); end
    reset = 1'b0;
    step;
  endtask

  task automatic test_read_address;
    request(1'b0, 10'd5, 9'd2, 1'b0, 36'h0);
    for (int c = 1; c <= 5; c++) begin
      step;
      if (c == 1) begin
        n_checks++; if (ram_addr !== 19'd642) begin n_fail++; $display("FAIL rd ram_addr: got %0d want 642", ram_addr); end
      end
      n_checks++; if (ram_we_b !== 1'b1) begin n_fail++; $display("FAIL rd we_b c%0d: got %0b want 1", c, ram_we_b); end
      n_checks++; if (bus.done_lpf !== (c == 4)) begin n_fail++; $display("FAIL rd done c%0d: got %0b want %0b", c, bus.done_lpf, c == 4); end
      if (c == 3) begin
        n_checks++; if (ram_oe !== 1'b0) begin n_fail++; $display("FAIL rd oe c3: got %0b want 0", ram_oe); end
      end
      if (c >= 4) begin
        n_checks++; if (bus.lpf_pixel_read !== 36'h123456789) begin n_fail++; $display("FAIL rd pixel c%0d: got %h want 123456789", c, bus.lpf_pixel_read); end
      end
      if (c == 4) bus.lpf_flag = 1'b0;
    end
  endtask

  task automatic test_write_readback;
    request(1'b1, 10'd639, 9'd479, 1'b1, 36'hABCDE0123);
    for (int c = 1; c <= 5; c++) begin
      step;
      if (c == 1) begin
        n_checks++; if (ram_addr !== 19'd307199) begin n_fail++; $display("FAIL wr ram_addr: got %0d want 307199", ram_addr); end
      end
      n_checks++; if (ram_we_b !== (c != 1)) begin n_fail++; $display("FAIL wr we_b c%0d: got %0b want %0b", c, ram_we_b, c != 1); end
      n_checks++; if (ram_oe !== (c == 3)) begin n_fail++; $display("FAIL wr oe c%0d: got %0b want %0b", c, ram_oe, c == 3); end
      if (c == 3) begin
        n_checks++; if (ram_wdata !== 36'hABCDE0123) begin n_fail++; $display("FAIL wr wdata: got %h want abcde0123", ram_wdata); end
      end
      n_checks++; if (bus.done_lpf !== (c == 4)) begin n_fail++; $display("FAIL wr done c%0d: got %0b want %0b", c, bus.done_lpf, c == 4); end
      n_checks++; if (bus.lpf_pixel_read !== 36'h123456789) begin n_fail++; $display("FAIL wr pixel held c%0d: got %h want 123456789", c, bus.lpf_pixel_read); end
      if (c == 4) bus.lpf_flag = 1'b0;
    end
    request(1'b0, 10'd639, 9'd479, 1'b1, 36'h0);
    for (int c = 1; c <= 5; c++) begin
      step;
      n_checks++; if (bus.done_lpf !== (c == 4)) begin n_fail++; $display("FAIL rb done c%0d: got %0b want %0b", c, bus.done_lpf, c == 4); end
      if (c == 4) begin
        n_checks++; if (bus.lpf_pixel_read !== 36'hABCDE0123) begin n_fail++; $display("FAIL rb pixel: got %h want abcde0123", bus.lpf_pixel_read); end
        bus.lpf_flag = 1'b0;
      end
    end
  endtask

  task automatic test_stale_flag;
    request(1'b1, 10'd5, 9'd2, 1'b0, 36'h00000BEEF);
    for (int c = 1; c <= 15; c++) begin
      step;
      if (c == 1 || c == 6 || c == 11) begin
        n_checks++; if (ram_addr !== 19'd642) begin n_fail++; $display("FAIL stale ram_addr c%0d: got %0d want 642", c, ram_addr); end
      end
      n_checks++; if (ram_we_b !== ((c % 5) != 1)) begin n_fail++; $display("FAIL stale we_b c%0d: got %0b want %0b", c, ram_we_b, (c % 5) != 1); end
      n_checks++; if (bus.done_lpf !== ((c % 5) == 4)) begin n_fail++; $display("FAIL stale done c%0d: got %0b want %0b", c, bus.done_lpf, (c % 5) == 4); end
      if (c == 14) bus.lpf_flag = 1'b0;
    end
  endtask

  task automatic test_out_of_range;
    request(1'b0, 10'd640, 9'd0, 1'b0, 36'h0);
    for (int c = 1; c <= 5; c++) begin
      step;
      n_checks++; if (ram_we_b !== 1'b1) begin n_fail++; $display("FAIL oor rd we_b c%0d: got %0b want 1", c, ram_we_b); end
      n_checks++; if (bus.done_lpf !== (c == 4)) begin n_fail++; $display("FAIL oor rd done c%0d: got %0b want %0b", c, bus.done_lpf, c == 4); end
      if (c == 4) begin
        n_checks++; if (bus.lpf_pixel_read !== 36'h0) begin n_fail++; $display("FAIL oor rd pixel: got %h want 0", bus.lpf_pixel_read); end
        bus.lpf_flag = 1'b0;
      end
    end
    request(1'b1, 10'd0, 9'd480, 1'b0, 36'h55AA55AA5);
    for (int c = 1; c <= 5; c++) begin
      step;
      n_checks++; if (ram_we_b !== 1'b1) begin n_fail++; $display("FAIL oor wr we_b c%0d: got %0b want 1", c, ram_we_b); end
      n_checks++; if (bus.done_lpf !== (c == 4)) begin n_fail++; $display("FAIL oor wr done c%0d: got %0b want %0b", c, bus.done_lpf, c == 4); end
      if (c == 4) bus.lpf_flag = 1'b0;
    end
  endtask

  task automatic test_reset_midop;
    request(1'b1, 10'd10, 9'd3, 1'b0, 36'h00005A5A5);
    step;
    n_checks++; if (ram_we_b !== 1'b0) begin n_fail++; $display("FAIL rst wr we_b c1: got %0b want 0", ram_we_b); end
    step;
    reset = 1'b1;
    bus.lpf_flag = 1'b0;
    #1;
    n_checks++; if (ram_we_b !== 1'b1) begin n_fail++; $display("FAIL rst we_b immediate: got %0b want 1", ram_we_b); end
    n_checks++; if (ram_oe !== 1'b0) begin n_fail++; $display("FAIL rst oe immediate: got %0b want 0", ram_oe); end
    step;
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      n_checks++; if (bus.done_lpf !== 1'b0) begin n_fail++; $display("FAIL rst no done +%0d: got %0b want 0", c, bus.done_lpf); end
      n_checks++; if (ram_oe !== 1'b0) begin n_fail++; $display("FAIL rst oe +%0d: got %0b want 0", c, ram_oe); end
      n_checks++; if (ram_we_b !== 1'b1) begin n_fail++; $display("FAIL rst we_b +%0d: got %0b want 1", c, ram_we_b); end
      n_checks++; if (bus.lpf_pixel_read !== 36'h0) begin n_fail++; $display("FAIL rst pixel +%0d: got %h want 0", c, bus.lpf_pixel_read); end
      if (c < 2) step;
    end
    request(1'b0, 10'd5, 9'd2, 1'b0, 36'h0);
    for (int c = 1; c <= 5; c++) begin
      step;
      n_checks++; if (bus.done_lpf !== (c == 4)) begin n_fail++; $display("FAIL post-rst done c%0d: got %0b want %0b", c, bus.done_lpf, c == 4); end
      if (c == 4) begin
        n_checks++; if (bus.lpf_pixel_read !== 36'h123456789) begin n_fail++; $display("FAIL post-rst pixel: got %h want 123456789", bus.lpf_pixel_read); end
        bus.lpf_flag = 1'b0;
      end
    end
  endtask

  task automatic test_hold;
    request(1'b0, 10'd0, 9'd3, 1'b0, 36'h0);
    for (int c = 1; c <= 5; c++) begin
      step;
      if (c == 4) begin
        n_checks++; if (bus.lpf_pixel_read !== 36'h1) begin n_fail++; $display("FAIL hold rd pixel: got %h want 1", bus.lpf_pixel_read); end
        bus.lpf_flag = 1'b0;
      end
    end
    request(1'b1, 10'd2, 9'd3, 1'b0, 36'h000000777);
    for (int c = 1; c <= 5; c++) begin
      step;
      // fields wiggling mid-transaction must not matter
      bus.lpf_wr = 1'b0;
      bus.lpf_x = 10'd700;
      bus.lpf_pixel_write = 36'h0;
      n_checks++; if (bus.lpf_pixel_read !== 36'h1) begin n_fail++; $display("FAIL hold wr pixel c%0d: got %h want 1", c, bus.lpf_pixel_read); end
      if (c == 3) begin
        n_checks++; if (ram_wdata !== 36'h000000777) begin n_fail++; $display("FAIL hold wr wdata: got %h want 777", ram_wdata); end
      end
      if (c == 4) bus.lpf_flag = 1'b0;
    end
    request(1'b0, 10'd2, 9'd3, 1'b0, 36'h0);
    for (int c = 1; c <= 5; c++) begin
      step;
      n_checks++; if (bus.lpf_pixel_read !== ((c >= 4) ? 36'h000000777 : 36'h1)) begin n_fail++; $display("FAIL hold rd2 pixel c%0d: got %h want %h", c, bus.lpf_pixel_read, (c >= 4) ? 36'h000000777 : 36'h1); end
      if (c == 4) bus.lpf_flag = 1'b0;
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset;
    test_read_address;
    test_write_readback;
    test_stale_flag;
    test_out_of_range;
    test_reset_midop;
    test_hold;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
